mc_main_controller: RTL
=======================

Name: mc_main_controller

Overview:
Multi-cycle control FSM for the MIPS datapath. It drives the 3-bit ALU operation select (000 and, 001 or, 010 add, 110 sub, 111 signed slt) and consumes the ALU zero flag. It sequences fetch, decode, execute, memory and write-back for the supported instruction subset. It sits beside the datapath and reads opcode/funct straight from the instruction register.

Parameters:
none

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends
funct  in  6  IR[5:0]; same stability as opcode
zero  in  1  ALU zero flag (y==0), combinational from datapath
alu_ctrl  out  3  ALU operation select
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=register B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_src  out  2  00=ALU result, 01=ALUOut register, 10=jump target {PC[31:28],IR[25:0],2'b00}
pc_en  out  1  PC load enable
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
state  out  4  current state, for debug and verification

Behaviour:
- Single 4-bit state register; all outputs decode combinationally from state, plus funct in R_EX and zero in BEQ_EX. Any output not listed for a state is 0; alu_ctrl defaults to 010.
- Encoding: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BEQ_EX=8, IMM_EX=9, IMM_WB=10, J_EX=11. Codes 12-15 go to FETCH on the next edge, with all outputs at default.
- rst high at a clock edge puts state at FETCH, including mid-instruction. No partial write completes after that edge. Outputs then show FETCH values.
- FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00, pc_en=1. Next: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Next state by opcode:
  - 100011 lw -> MEM_ADR
  - 101011 sw -> MEM_ADR
  - 000000 R -> R_EX
  - 000100 beq -> BEQ_EX
  - 001000 addi -> IMM_EX
  - 001010 slti -> IMM_EX
  - 000010 j -> J_EX
  - any other opcode -> FETCH (treated as a nop)
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next: MEM_RD if lw, MEM_WR if sw.
- MEM_RD: i_or_d=1, mem_read=1. Next: MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Next: FETCH.
- R_EX: alu_src_a=1, alu_src_b=00. alu_ctrl by funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010
  Next: R_WB.
- R_WB: reg_dst=1, mem_to_reg=0. reg_write=1 only for the five legal functs; illegal funct suppresses the write. Next: FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_en=zero. Next: FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=10, alu_ctrl=010 for addi, 111 for slti. Next: IMM_WB.
- IMM_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
- J_EX: pc_src=10, pc_en=1. Next: FETCH.
- Cycles per instruction, counting FETCH:
  - lw 5
  - sw, R-type, addi, slti 4
  - beq, j 3
  - unknown opcode 2
- Invariants:
  - mem_read and mem_write are never both high.
  - pc_en in BEQ_EX follows zero in the same cycle.
  - reg_write is never high outside MEM_WB, R_WB and IMM_WB.

Test Plan:
- rst=1 for 2 cycles, then opcode=000000, funct=100010 -> state sequence 0,1,6,7,0. In state 6 alu_ctrl=110. In state 7 reg_write=1 and reg_dst=1.
- opcode=100011 -> states 0,1,2,3,4,0. In state 3 i_or_d=1 and mem_read=1. In state 4 mem_to_reg=1 and reg_write=1. Then opcode=101011 -> states 0,1,2,5,0, with mem_write=1 only in state 5.
- opcode=000100, zero=1 in BEQ_EX -> pc_en=1, pc_src=01, alu_ctrl=110. Repeat with zero=0 -> pc_en=0. Both cases return to FETCH after 3 cycles.
- opcode=001010 -> IMM_EX has alu_ctrl=111, alu_src_b=10; IMM_WB has reg_write=1, reg_dst=0. opcode=001000 -> IMM_EX has alu_ctrl=010.
- opcode=000010 -> J_EX has pc_src=10, pc_en=1. Then opcode=111111 -> states 0,1,0 with no reg_write or mem_write. Then funct=000111 with opcode=000000 -> R_WB has reg_write=0.
- In MEM_RD assert rst -> next state=0, no reg_write at any point. Then run a full lw completing normally (5 cycles).

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath.
// The datapath supplies opcode/funct from the instruction register and the
// ALU zero flag; the controller returns every datapath select/enable and its
// current state for debug.
//   master : controller side (consumes opcode/funct/zero, drives controls)
//   slave  : datapath side (drives opcode/funct/zero, consumes controls)
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, state
  );

  modport slave (
    output opcode, funct, zero,
    input  alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, state
  );
endinterface

// File: rtl/mc_main_controller.sv
// Multi-cycle MIPS main controller: sequences fetch, decode, execute, memory
// and write-back for lw, sw, R-type (add/sub/and/or/slt), beq, addi, slti, j.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, returns the FSM to FETCH
//   bus  : mc_ctrl_if.master -- opcode/funct/zero in, datapath controls and
//          debug state out
// All controls decode combinationally from the state register, with funct
// consulted in R_EX/R_WB, opcode in IMM_EX and zero in BEQ_EX.
module mc_main_controller (
  input  logic           clk,
  input  logic           rst,
  mc_ctrl_if.master      bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    R_EX    = 4'd6,
    R_WB    = 4'd7,
    BEQ_EX  = 4'd8,
    IMM_EX  = 4'd9,
    IMM_WB  = 4'd10,
    J_EX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Illegal functs still run through R_EX/R_WB but must not write back.
  function automatic logic funct_legal(input logic [5:0] f);
    logic ok;
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
      default:                                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] alu_ctrl_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] pc_src_s;
  logic       pc_en_s;
  logic       i_or_d_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control decode; every output defaults to 0 (ALU to add).
  always_comb begin
    state_next_s = FETCH;
    alu_ctrl_s   = ALU_ADD;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    pc_src_s     = 2'b00;
    pc_en_s      = 1'b0;
    i_or_d_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s   = 1'b1;
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b01;
        pc_en_s      = 1'b1;
        state_next_s = DECODE;
      end
      DECODE: begin
        // PC + (imm<<2) is parked in ALUOut as the speculative branch target.
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:     state_next_s = MEM_ADR;
          OP_R:             state_next_s = R_EX;
          OP_BEQ:           state_next_s = BEQ_EX;
          OP_ADDI, OP_SLTI: state_next_s = IMM_EX;
          OP_J:             state_next_s = J_EX;
          default:          state_next_s = FETCH;
        endcase
      end
      MEM_ADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_SW) begin
          state_next_s = MEM_WR;
        end else begin
          state_next_s = MEM_RD;
        end
      end
      MEM_RD: begin
        i_or_d_s     = 1'b1;
        mem_read_s   = 1'b1;
        state_next_s = MEM_WB;
      end
      MEM_WB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      MEM_WR: begin
        i_or_d_s    = 1'b1;
        mem_write_s = 1'b1;
      end
      R_EX: begin
        alu_src_a_s = 1'b1;
        case (bus.funct)
          6'b100010: alu_ctrl_s = ALU_SUB;
          6'b100100: alu_ctrl_s = ALU_AND;
          6'b100101: alu_ctrl_s = ALU_OR;
          6'b101010: alu_ctrl_s = ALU_SLT;
          default:   alu_ctrl_s = ALU_ADD;
        endcase
        state_next_s = R_WB;
      end
      R_WB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = funct_legal(bus.funct);
      end
      BEQ_EX: begin
        alu_src_a_s = 1'b1;
        alu_ctrl_s  = ALU_SUB;
        pc_src_s    = 2'b01;
        pc_en_s     = bus.zero;
      end
      IMM_EX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_SLTI) begin
          alu_ctrl_s = ALU_SLT;
        end else begin
          alu_ctrl_s = ALU_ADD;
        end
        state_next_s = IMM_WB;
      end
      IMM_WB: begin
        reg_write_s = 1'b1;
      end
      J_EX: begin
        pc_src_s = 2'b10;
        pc_en_s  = 1'b1;
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  assign bus.state      = state_r;
  assign bus.alu_ctrl   = alu_ctrl_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.pc_en      = pc_en_s;
  assign bus.i_or_d     = i_or_d_s;
  assign bus.mem_read   = mem_read_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.reg_write  = reg_write_s;

endmodule
